// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls later MDU ops.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9, OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [3:0]       r_op;
  logic             r_busy;

  logic w_is_mul, w_is_div, w_launch;

  always_comb begin
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_launch = (r_state == S_IDLE) && start && (w_is_mul || w_is_div);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_next = S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One shared multiplier: sign-extending into 2*WIDTH makes the low half exact for signed ops.
  logic                 w_sgn;
  logic [2*WIDTH-1:0]   w_ma, w_mb, w_prod;
  assign w_sgn  = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD) || (r_op == OP_MSUB);
  assign w_ma   = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_mb   = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Divide on magnitudes then fix signs; min/-1 wraps naturally to min with zero remainder.
  logic             w_neg_a, w_neg_b, w_dbz;
  logic [WIDTH-1:0] w_da, w_db, w_db_safe, w_q, w_r, w_quo, w_rem;
  assign w_neg_a   = w_sgn & r_a[WIDTH-1];
  assign w_neg_b   = w_sgn & r_b[WIDTH-1];
  assign w_da      = w_neg_a ? (~r_a + 1'b1) : r_a;
  assign w_db      = w_neg_b ? (~r_b + 1'b1) : r_b;
  assign w_dbz     = (r_b == '0);
  assign w_db_safe = w_dbz ? {{(WIDTH-1){1'b0}}, 1'b1} : w_db;
  assign w_q       = w_da / w_db_safe;
  assign w_r       = w_da % w_db_safe;
  assign w_quo     = (w_neg_a ^ w_neg_b) ? (~w_q + 1'b1) : w_q;
  assign w_rem     = w_neg_a ? (~w_r + 1'b1) : w_r;

  logic               w_wr;
  logic [2*WIDTH-1:0] w_res;
  always_comb begin
    w_wr  = 1'b0;
    w_res = {r_hi, r_lo};
    case (r_op)
      OP_MULT, OP_MULTU: begin w_wr = 1'b1;   w_res = w_prod;       end
      OP_DIV, OP_DIVU:   begin w_wr = !w_dbz; w_res = {w_rem, w_quo}; end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin w_wr = 1'b1; w_res = {r_hi, r_lo} + w_prod; end
      OP_MSUB, OP_MSUBU: begin w_wr = 1'b1; w_res = {r_hi, r_lo} - w_prod; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_busy <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (w_launch) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_busy <= 1'b1;
      r_cnt  <= w_is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
    end else if (r_state == S_RUN) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        if (w_wr) {r_hi, r_lo} <= w_res;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (start) begin
      if (op == OP_MTHI) r_hi <= a;
      if (op == OP_MTLO) r_lo <= a;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule
